// File: rtl/mmsp430_ctm_tracer.sv
// mmsp430_ctm_tracer
//   Control-transfer monitor for the MSP430 trace path. Turns jump, branch, call and return
//   instructions into timestamped event records, queues them in a FIFO and drains them over a
//   valid/ready stream. When the FIFO is full, dropped candidates are counted. The count is
//   reported in-band by an overflow record (type 3) that is pushed as soon as a slot frees up.
//
// Configuration macro:
//   MMSP430_CTM_TIMESTAMP_EN - defined: a free-running timestamp counter fills the ts field.
//                              undefined: the ts field is constant 0 and the width is unchanged.
//
// Ports:
//   clk_i          - clock
//   rstn_i         - asynchronous active-low reset
//   trace_port_i   - mmsp430_trace_exec record (insn, pc, jb, jal, jr, jbtarget, valid,
//                    wbdata, wbreg, wben), MSB first
//   trace_enable_i - capture enable; buffered events keep draining while low
//   evt_valid_o    - FIFO head is valid
//   evt_ready_i    - consumer accepts the head entry
//   evt_data_o     - {type[1:0], ts[TS_W-1:0], src[31:0], dst[31:0]}
//   evt_overflow_o - sticky flag, set on the first dropped event

module mmsp430_ctm_tracer #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned TS_W  = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic [137:0]      trace_port_i,
   input  logic              trace_enable_i,
   output logic              evt_valid_o,
   input  logic              evt_ready_i,
   output logic [TS_W+65:0]  evt_data_o,
   output logic              evt_overflow_o
);

   localparam int unsigned EvtW  = TS_W + 66;
   localparam int unsigned PtrW  = $clog2(DEPTH);
   localparam int unsigned FillW = $clog2(DEPTH) + 1;

   localparam logic [1:0] TypeJb  = 2'd0;
   localparam logic [1:0] TypeJal = 2'd1;
   localparam logic [1:0] TypeJr  = 2'd2;
   localparam logic [1:0] TypeOvf = 2'd3;

   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] pc;
      logic        jb;
      logic        jal;
      logic        jr;
      logic [31:0] jbtarget;
      logic        valid;
      logic [31:0] wbdata;
      logic [4:0]  wbreg;
      logic        wben;
   } trace_exec_t;

   typedef enum logic [0:0] {StIdle, StLost} state_e;

   trace_exec_t trace;
   assign trace = trace_exec_t'(trace_port_i);

   // Write-back fields are not needed for control-transfer events.
   logic unused_trace;
   assign unused_trace = ^{trace.insn, trace.wbdata, trace.wbreg, trace.wben};

   // ------------------------------------------------------------------------------------------
   // Timestamp
   // ------------------------------------------------------------------------------------------
   logic [TS_W-1:0] ts;

`ifdef MMSP430_CTM_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
      end
   end

   assign ts = ts_q;
`else
   assign ts = '0;
`endif

   // ------------------------------------------------------------------------------------------
   // FIFO and overflow tracking state
   // ------------------------------------------------------------------------------------------
   logic [EvtW-1:0]  mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [FillW-1:0] count_q, count_d;
   logic [CNT_W-1:0] drops_q, drops_d;
   logic             ovf_q, ovf_d;
   state_e           state_q, state_d;

   logic             pop, slot, cand, push;
   logic [1:0]       cand_type;
   logic [EvtW-1:0]  cand_rec, ovf_rec, push_rec;

   assign evt_valid_o    = (count_q != '0);
   assign evt_data_o     = evt_valid_o ? mem_q[rd_ptr_q] : '0;
   assign evt_overflow_o = ovf_q;

   assign pop  = evt_valid_o & evt_ready_i;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign slot = (count_q != FillW'(DEPTH)) | pop;
   assign cand = trace_enable_i & trace.valid & (trace.jal | trace.jr | trace.jb);

   always_comb begin
      cand_type = TypeJb;
      if (trace.jal) begin
         cand_type = TypeJal;
      end else if (trace.jr) begin
         cand_type = TypeJr;
      end
   end

   assign cand_rec = {cand_type, ts, trace.pc, trace.jbtarget};
   assign ovf_rec  = {TypeOvf, ts, 32'(drops_q), 32'h0};

   // Overflow FSM: in StLost the pending overflow record owns the next free slot, so any
   // candidate arriving in that cycle is dropped and starts a fresh drop count.
   always_comb begin
      state_d  = state_q;
      drops_d  = drops_q;
      ovf_d    = ovf_q;
      push     = 1'b0;
      push_rec = cand_rec;
      case (state_q)
         StIdle: begin
            if (cand) begin
               if (slot) begin
                  push = 1'b1;
               end else begin
                  drops_d = CNT_W'(1);
                  ovf_d   = 1'b1;
                  state_d = StLost;
               end
            end
         end
         StLost: begin
            if (slot) begin
               push     = 1'b1;
               push_rec = ovf_rec;
               if (cand) begin
                  drops_d = CNT_W'(1);
                  ovf_d   = 1'b1;
               end else begin
                  drops_d = '0;
                  state_d = StIdle;
               end
            end else if (cand) begin
               ovf_d = 1'b1;
               if (drops_q != '1) begin
                  drops_d = drops_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + FillW'(1);
      end else if (!push && pop) begin
         count_d = count_q - FillW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drops_q  <= '0;
         ovf_q    <= 1'b0;
         state_q  <= StIdle;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         count_q <= count_d;
         drops_q <= drops_d;
         ovf_q   <= ovf_d;
         state_q <= state_d;
      end
   end

   // Storage needs no reset: the output is gated by evt_valid_o.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_rec;
      end
   end

endmodule

// File: doc/mmsp430_ctm_tracer.md
# mmsp430_ctm_tracer

Control-transfer monitor for the MSP430 debug trace path. It consumes the per-instruction `mmsp430_trace_exec` record from the core's trace port. It extracts jump, branch, call and return events, timestamps them, and buffers them in a FIFO. The FIFO drains over a valid/ready stream toward the debug-interconnect packetizer. FIFO overflow is never silent: dropped events are counted and reported in-band with a dedicated overflow record.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `TS_W`, 16: timestamp width, 8..32.
- `CNT_W`, 16: dropped-event counter width, ≤32.
- `clk` in 1: single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `trace_port` in 138: `opensocdebug::mmsp430_trace_exec` record (insn, pc, jb, jal, jr, jbtarget, valid, wbdata, wbreg, wben).
- `trace_enable` in 1: when 0, no events are captured; buffered events keep draining.
- `evt_valid` out 1: head FIFO entry valid.
- `evt_ready` in 1: consumer accepts the head entry.
- `evt_data` out 2+TS_W+64: `{type[1:0], ts[TS_W-1:0], src[31:0], dst[31:0]}`, MSB first.
- `evt_overflow` out 1: sticky; set on first drop, cleared only by reset.

## Operation
- Free-running timestamp `ts` increments every cycle and wraps modulo 2^TS_W.
- An event is a candidate when `trace_enable && valid && (jal||jr||jb)`.
- Type encoding, with priority jal > jr > jb: 1=jal (call), 2=jr (return/indirect), 0=jb (branch/jump).
- Candidate record: src=`pc`, dst=`jbtarget`, ts=current `ts`.
- Type 3 is the overflow record: src=drop count zero-extended, dst=0, ts=current `ts`.
- Push acceptance: a push is accepted when `count < DEPTH`, or when a pop happens in the same cycle.
- Overflow state machine:
  - IDLE: the candidate is pushed if accepted. Otherwise `drops` is set to 1 and the FSM goes to LOST.
  - LOST: each cycle a push slot is available, the overflow record is pushed, `drops` clears to 0, and the FSM returns to IDLE. In that same cycle, any candidate is dropped and `drops` is reloaded to 1, which keeps the FSM in LOST.
  - LOST: while no slot is available, each candidate increments `drops`, saturating at 2^CNT_W−1.
- Overflow records are never dropped. Event order in the FIFO equals program order.
- Pop occurs when `evt_valid && evt_ready`.

## Timing
- Reset values: `evt_valid`=0, `evt_data`=0, `evt_overflow`=0, FIFO empty, `ts`=0, `drops`=0, FSM=IDLE.
- Reset mid-operation immediately discards all buffered events and pending drop counts.
- Latency: a candidate sampled at edge N appears on `evt_data` with `evt_valid`=1 after edge N, when the FIFO was empty. There is no combinational input-to-output path.
- Throughput: one push and one pop per cycle.
- `evt_data` is stable while `evt_valid && !evt_ready`.
- `evt_valid` deasserts only after a pop that empties the FIFO.
- The `ts` captured for an event is the value before that edge's increment.

## Configuration
- `MMSP430_CTM_TIMESTAMP_EN` defined: the timestamp counter is instantiated and the ts field carries its value.
- Macro undefined: no counter is built, the ts field is constant 0, and the `evt_data` width is unchanged.

## Test plan
- Single jal: pc=0x1000, jbtarget=0x2000, ts=5 at capture, ready=1 → next cycle `evt_valid`=1, type=1, src=0x1000, dst=0x2000, ts=5 (0 if macro undefined).
- Flags jb=jr=jal=1 together → type=1. Flags jb=jr=1 → type=2. Flags valid=0 with jal=1 → no event. `trace_enable`=0 with jal=1 → no event.
- DEPTH=8, `evt_ready`=0, 11 consecutive branches → 8 queued; `evt_overflow`=1; FSM in LOST with drops=3. Raise ready for 1 cycle with no candidates → one pop, then the overflow record (type 3, src=3) becomes the last entry.
- Full FIFO, pop and candidate in the same cycle → candidate accepted, `evt_overflow` stays 0.
- LOST state: slot frees in the same cycle as a candidate → overflow record pushed, candidate dropped. Next overflow record reports src=1.
- Assert `rstn`=0 mid-burst with 5 entries queued → `evt_valid`=0 immediately. After release, ts restarts at 0 and `evt_overflow`=0.
